// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised integer register file with NREAD combinational read ports,
// one write port with optional write-through bypass, and a per-register busy scoreboard.
module reg_file_sb #(
   parameter  int XLEN   = 32,
   parameter  int NREGS  = 32,
   parameter  int NREAD  = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREAD*AW-1:0]   rs,
   input  logic [NREAD-1:0]      rs_en,
   output logic [NREAD*XLEN-1:0] readdata,
   output logic [NREAD-1:0]      rs_busy,
   output logic                  stall,
   input  logic                  write,
   input  logic [AW-1:0]         rd,
   input  logic [XLEN-1:0]       writedata,
   input  logic                  issue,
   input  logic [AW-1:0]         issue_rd,
   output logic [NREGS-1:0]      busy
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic             w_wr_en;

   assign w_wr_en = write && (rd != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[rd] <= writedata;
      end
   end

   // Issue beats a same-edge write: the newly issued producer supersedes the old one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (issue && (issue_rd == AW'(r)))  r_busy[r] <= 1'b1;
            else if (write && (rd == AW'(r)))   r_busy[r] <= 1'b0;
         end
      end
   end

   assign busy = r_busy;

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] w_rs;
      logic          w_fwd;
      logic          w_iss;
      assign w_rs  = rs[k*AW +: AW];
      assign w_fwd = (BYPASS != 0) && write && (rd == w_rs);
      assign w_iss = issue && (issue_rd == w_rs);
      // Reset forces outputs low even if a write is being forwarded.
      assign readdata[k*XLEN +: XLEN] = (reset || (w_rs == '0)) ? '0 :
                                        w_fwd ? writedata : r_regs[w_rs];
      assign rs_busy[k] = !reset && (w_rs != '0) && !(w_fwd && !w_iss) && r_busy[w_rs];
   end

   assign stall = |(rs_en & rs_busy);

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: A (bypass) and B (no bypass) share inputs; C is a 16x64, 3-port build.
module tb_reg_file_sb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [9:0]   a_rs;  logic [1:0] a_en; logic a_wr; logic [4:0] a_rd; logic [31:0] a_wd;
   logic         a_iss; logic [4:0] a_ird;
   logic [63:0]  a_q, b_q; logic [1:0] a_rb, b_rb; logic a_st, b_st; logic [31:0] a_busy, b_busy;
   logic [11:0]  c_rs;  logic [2:0] c_en; logic c_wr; logic [3:0] c_rd; logic [63:0] c_wd;
   logic         c_iss; logic [3:0] c_ird;
   logic [191:0] c_q;   logic [2:0] c_rb; logic c_st; logic [15:0] c_busy;

   reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_a (
      .clk(clk), .reset(rst), .rs(a_rs), .rs_en(a_en), .readdata(a_q), .rs_busy(a_rb),
      .stall(a_st), .write(a_wr), .rd(a_rd), .writedata(a_wd), .issue(a_iss),
      .issue_rd(a_ird), .busy(a_busy));
   reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_b (
      .clk(clk), .reset(rst), .rs(a_rs), .rs_en(a_en), .readdata(b_q), .rs_busy(b_rb),
      .stall(b_st), .write(a_wr), .rd(a_rd), .writedata(a_wd), .issue(a_iss),
      .issue_rd(a_ird), .busy(b_busy));
   reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(1)) u_c (
      .clk(clk), .reset(rst), .rs(c_rs), .rs_en(c_en), .readdata(c_q), .rs_busy(c_rb),
      .stall(c_st), .write(c_wr), .rd(c_rd), .writedata(c_wd), .issue(c_iss),
      .issue_rd(c_ird), .busy(c_busy));

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: architectural state per configuration (0 = A/B, 1 = C).
   logic [63:0] m_reg  [2][32];
   bit          m_busy [2][32];

   function automatic void get_in(input int cfg, output bit wr, output int rd,
                                  output logic [63:0] wd, output bit iss, output int ird);
      if (cfg == 0) begin
         wr = a_wr; rd = int'(a_rd); wd = {32'h0, a_wd}; iss = a_iss; ird = int'(a_ird);
      end else begin
         wr = c_wr; rd = int'(c_rd); wd = c_wd; iss = c_iss; ird = int'(c_ird);
      end
   endfunction

   function automatic logic [63:0] exp_q(input int cfg, input bit byp, input int a);
      bit wr, iss; int rd, ird; logic [63:0] wd;
      get_in(cfg, wr, rd, wd, iss, ird);
      if (rst || a == 0) return 64'h0;
      if (byp && wr && rd == a) return wd;
      return m_reg[cfg][a];
   endfunction

   function automatic bit exp_rb(input int cfg, input bit byp, input int a);
      bit wr, iss; int rd, ird; logic [63:0] wd;
      get_in(cfg, wr, rd, wd, iss, ird);
      if (rst || a == 0) return 1'b0;
      if (byp && wr && rd == a && !(iss && ird == a)) return 1'b0;
      return m_busy[cfg][a];
   endfunction

   function automatic logic [31:0] exp_busy(input int cfg);
      logic [31:0] v = '0;
      for (int r = 0; r < 32; r++) v[r] = m_busy[cfg][r];
      return v;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 32; r++) begin m_reg[c][r] = '0; m_busy[c][r] = 1'b0; end
   endtask

   task automatic model_edge();
      bit wr, iss; int rd, ird; logic [63:0] wd;
      for (int c = 0; c < 2; c++) begin
         get_in(c, wr, rd, wd, iss, ird);
         if (wr && rd != 0) m_reg[c][rd] = wd;
         if (iss && ird != 0) m_busy[c][ird] = 1'b1;
         if (wr && rd != 0 && !(iss && ird == rd)) m_busy[c][rd] = 1'b0;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic check_all();
      bit sa, sb, sc; int a;
      #1;
      sa = 0; sb = 0; sc = 0;
      for (int k = 0; k < 2; k++) begin
         a = int'(a_rs[k*5 +: 5]);
         chk("A_readdata", {32'h0, a_q[k*32 +: 32]}, exp_q(0, 1'b1, a));
         chk("B_readdata", {32'h0, b_q[k*32 +: 32]}, exp_q(0, 1'b0, a));
         chk("A_rs_busy", 64'(a_rb[k]), 64'(exp_rb(0, 1'b1, a)));
         chk("B_rs_busy", 64'(b_rb[k]), 64'(exp_rb(0, 1'b0, a)));
         sa |= a_en[k] & exp_rb(0, 1'b1, a);
         sb |= a_en[k] & exp_rb(0, 1'b0, a);
      end
      chk("A_stall", 64'(a_st), 64'(sa));
      chk("B_stall", 64'(b_st), 64'(sb));
      chk("A_busy", 64'(a_busy), 64'(exp_busy(0)));
      chk("B_busy", 64'(b_busy), 64'(exp_busy(0)));
      for (int k = 0; k < 3; k++) begin
         a = int'(c_rs[k*4 +: 4]);
         chk("C_readdata", c_q[k*64 +: 64], exp_q(1, 1'b1, a));
         chk("C_rs_busy", 64'(c_rb[k]), 64'(exp_rb(1, 1'b1, a)));
         sc |= c_en[k] & exp_rb(1, 1'b1, a);
      end
      chk("C_stall", 64'(c_st), 64'(sc));
      chk("C_busy", 64'(c_busy), 64'(exp_busy(1) & 32'hFFFF));
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst) model_edge();
      #2;
   endtask

   task automatic idle();
      a_wr = 0; a_iss = 0; c_wr = 0; c_iss = 0;
   endtask

   typedef struct {
      int          r0, r1;
      logic [31:0] e0, e1;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tv [5];
      tv[0] = '{14, 29, 32'd30, 32'd60};
      tv[1] = '{ 0,  1, 32'd0,  32'd4};
      tv[2] = '{31,  0, 32'd64, 32'd0};
      tv[3] = '{ 2,  2, 32'd6,  32'd6};
      tv[4] = '{ 5, 20, 32'd12, 32'd42};

      a_rs = '0; a_en = '0; a_rd = '0; a_wd = '0; a_ird = '0;
      c_rs = '0; c_en = '0; c_rd = '0; c_wd = '0; c_ird = '0;
      idle();
      model_clear();
      check_all();
      chk("reset_busy", 64'(a_busy), 64'h0);
      repeat (2) cyc();
      rst = 0;
      check_all();

      // Reset mid-run, between edges
      a_wr = 1; a_rd = 5; a_wd = 32'hDEAD_BEEF; check_all(); cyc();
      idle(); a_iss = 1; a_ird = 7; check_all(); cyc();
      idle(); a_rs = {5'd0, 5'd5}; check_all();
      chk("x5_written", {32'h0, a_q[31:0]}, 64'hDEAD_BEEF);
      chk("x7_busy", 64'(a_busy[7]), 64'h1);
      a_wr = 1; a_rd = 6; a_wd = 32'h1111;
      rst = 1; model_clear(); check_all();
      chk("x5_in_reset", {32'h0, a_q[31:0]}, 64'h0);
      chk("busy_in_reset", 64'(a_busy), 64'h0);
      rst = 0; idle(); cyc();

      // Fill and readback
      for (int i = 1; i < 32; i++) begin
         a_wr = 1; a_rd = 5'(i); a_wd = 32'((i + 1) * 2); cyc();
      end
      idle();
      tv[4].e1 = 32'd42;
      for (int i = 0; i < 5; i++) begin
         a_rs = {5'(tv[i].r1), 5'(tv[i].r0)}; check_all();
         chk("fill_A_p0", {32'h0, a_q[31:0]},  {32'h0, tv[i].e0});
         chk("fill_A_p1", {32'h0, a_q[63:32]}, {32'h0, tv[i].e1});
         chk("fill_B_p0", {32'h0, b_q[31:0]},  {32'h0, tv[i].e0});
      end
      a_rs = '0; a_wr = 1; a_rd = 0; a_wd = 32'hFFFF_FFFF; check_all();
      chk("x0_during_write", {32'h0, a_q[31:0]}, 64'h0);
      cyc(); idle(); check_all();
      chk("x0_after_write", {32'h0, a_q[31:0]}, 64'h0);

      // Bypass vs no bypass
      a_wr = 1; a_rd = 20; a_wd = 32'h1; cyc();
      a_wr = 1; a_rd = 20; a_wd = 32'hF00D; a_rs = {5'd0, 5'd20}; check_all();
      chk("bypass_A", {32'h0, a_q[31:0]}, 64'hF00D);
      chk("nobypass_B", {32'h0, b_q[31:0]}, 64'h1);
      cyc(); idle(); check_all();
      chk("nobypass_B_after", {32'h0, b_q[31:0]}, 64'hF00D);

      // Hazard on x9
      a_iss = 1; a_ird = 9; cyc(); idle();
      a_rs = {5'd9, 5'd0}; a_en = 2'b10;
      for (int i = 0; i < 3; i++) begin
         check_all();
         chk("hazard_A_stall", 64'(a_st), 64'h1);
         chk("hazard_B_stall", 64'(b_st), 64'h1);
         chk("hazard_A_rsbusy1", 64'(a_rb[1]), 64'h1);
         cyc();
      end
      a_wr = 1; a_rd = 9; a_wd = 32'h42; check_all();
      chk("wb_A_stall", 64'(a_st), 64'h0);
      chk("wb_B_stall", 64'(b_st), 64'h1);
      chk("wb_A_data", {32'h0, a_q[63:32]}, 64'h42);
      cyc(); idle(); check_all();
      chk("wb_B_stall_next", 64'(b_st), 64'h0);
      chk("wb_B_data", {32'h0, b_q[63:32]}, 64'h42);
      chk("wb_busy9", 64'(a_busy[9]), 64'h0);
      a_en = 2'b00;

      // Simultaneous issue and write to x3
      a_iss = 1; a_ird = 3; cyc();
      a_iss = 1; a_ird = 3; a_wr = 1; a_rd = 3; a_wd = 32'h1234; a_rs = {5'd0, 5'd3};
      check_all();
      chk("sim_A_rsbusy", 64'(a_rb[0]), 64'h1);
      cyc(); idle(); check_all();
      chk("sim_busy3", 64'(a_busy[3]), 64'h1);
      chk("sim_A_data", {32'h0, a_q[31:0]}, 64'h1234);
      chk("sim_B_data", {32'h0, b_q[31:0]}, 64'h1234);

      // Wide build: three ports, 64-bit data, stall gated by rs_en
      c_wr = 1; c_rd = 1; c_wd = 64'h0123_4567_89AB_CDEF; cyc();
      c_wr = 1; c_rd = 2; c_wd = 64'hFEDC_BA98_7654_3210; cyc();
      c_wr = 1; c_rd = 3; c_wd = 64'hA5A5_5A5A_C3C3_3C3C; cyc();
      idle(); c_iss = 1; c_ird = 5; cyc(); idle();
      c_rs = {4'd3, 4'd2, 4'd1}; c_en = 3'b111; check_all();
      chk("C_p0", c_q[63:0],    64'h0123_4567_89AB_CDEF);
      chk("C_p1", c_q[127:64],  64'hFEDC_BA98_7654_3210);
      chk("C_p2", c_q[191:128], 64'hA5A5_5A5A_C3C3_3C3C);
      chk("C_no_stall", 64'(c_st), 64'h0);
      c_rs = {4'd5, 4'd2, 4'd1}; c_en = 3'b011; check_all();
      chk("C_rsbusy2", 64'(c_rb[2]), 64'h1);
      chk("C_stall_gated", 64'(c_st), 64'h0);
      c_en = 3'b111; check_all();
      chk("C_stall_en", 64'(c_st), 64'h1);

      // Randomised traffic against the model, with occasional held reset
      for (int n = 0; n < 400; n++) begin
         a_rs  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         a_en  = 2'($urandom);
         a_wr  = 1'($urandom);
         a_rd  = 5'($urandom_range(0, 7));
         a_wd  = $urandom;
         a_iss = ($urandom_range(0, 2) == 0);
         a_ird = 5'($urandom_range(0, 7));
         c_rs  = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
         c_en  = 3'($urandom);
         c_wr  = 1'($urandom);
         c_rd  = 4'($urandom_range(0, 7));
         c_wd  = {$urandom, $urandom};
         c_iss = ($urandom_range(0, 2) == 0);
         c_ird = 4'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) begin
            rst = 1; model_clear(); check_all(); cyc(); rst = 0;
         end else begin
            check_all(); cyc();
         end
      end
      idle(); check_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
